rc4_decryptor: RTL and testbench

RC4_DECRYPTOR -- requirements
Module: rc4_decryptor

---
 rtl/rc4_pkg.sv | 22 ++
 rtl/edge_detector.sv | 25 ++
 rtl/rc4_decryptor.sv | 155 +++++++++++++++
 tb/tb_rc4_decryptor.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 key-schedule blocks (shuffler and decryptor).
// Holds the decryptor state encoding and the default memory geometry.
package rc4_pkg;

  localparam int DEFAULT_RAM_WIDTH  = 8;   // S / message / result data width
  localparam int DEFAULT_RAM_LENGTH = 8;   // S address width (256 entries)
  localparam int DEFAULT_MSG_LENGTH = 32;  // message bytes per run

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ISSUE_I   = 4'd1,
    WAIT_SI   = 4'd2,
    READ_SI   = 4'd3,
    WAIT_SJ   = 4'd4,
    READ_SJ   = 4'd5,
    WRITE_J   = 4'd6,
    ISSUE_F   = 4'd7,
    WAIT_F    = 4'd8,
    WRITE_OUT = 4'd9
  } dec_state_t;

endpackage

// File: rtl/edge_detector.sv
// Rising-edge detector for a level request.
// Ports:
//   clk   - clock
//   reset - synchronous active-high reset
//   sig   - level input
//   rise  - high for the cycle in which sig is high and was low last cycle
module edge_detector (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic rise
);

  logic sig_q;

  // Tracking the input during reset means a level that is already high when
  // reset releases is not mistaken for a fresh edge.
  always_ff @(posedge clk) begin
    if (reset) sig_q <= sig;
    else       sig_q <= sig;
  end

  assign rise = sig & ~sig_q & ~reset;

endmodule

// File: rtl/rc4_decryptor.sv
// RC4 PRGA decryptor working on an already-shuffled S memory.
// For each message byte k: i=i+1, j=j+S[i], swap S[i]/S[j],
// dec[k] = S[S[i]+S[j]] ^ enc[k]. Every memory-facing output is registered.
// Ports:
//   clk, reset                       - clock, synchronous active-high reset
//   start                            - level request, a run begins on its rising edge
//   finished                         - one-cycle pulse after the last result write
//   s_address/s_ram_in/s_write_enable, s_ram_out - S RAM (1-cycle read latency)
//   msg_address, msg_rom_out         - encrypted message ROM (1-cycle latency)
//   dec_ram_in, dec_write_enable     - result RAM, addressed by msg_address
//
// state     | meaning
// IDLE      | waiting for a start edge
// ISSUE_I   | advance i, present i on S address
// WAIT_SI   | S read latency
// READ_SI   | capture S[i], advance j, present j
// WAIT_SJ   | S read latency
// READ_SJ   | capture S[j], launch write S[i] <= S[j]
// WRITE_J   | launch write S[j] <= S[i]
// ISSUE_F   | present S[i]+S[j] and message index k
// WAIT_F    | S / ROM read latency
// WRITE_OUT | launch result write, next byte or finish
module rc4_decryptor
  import rc4_pkg::*;
#(
  parameter int RAM_WIDTH  = DEFAULT_RAM_WIDTH,
  parameter int RAM_LENGTH = DEFAULT_RAM_LENGTH,
  parameter int MSG_LENGTH = DEFAULT_MSG_LENGTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  output logic                          finished,
  input  logic [RAM_WIDTH-1:0]          s_ram_out,
  output logic [RAM_LENGTH-1:0]         s_address,
  output logic [RAM_WIDTH-1:0]          s_ram_in,
  output logic                          s_write_enable,
  input  logic [RAM_WIDTH-1:0]          msg_rom_out,
  output logic [$clog2(MSG_LENGTH)-1:0] msg_address,
  output logic [RAM_WIDTH-1:0]          dec_ram_in,
  output logic                          dec_write_enable
);

  localparam int KW = $clog2(MSG_LENGTH);
  localparam logic [KW-1:0] K_LAST = KW'(MSG_LENGTH - 1);

  dec_state_t state, next_state;

  logic [RAM_LENGTH-1:0] i, j;
  logic [KW-1:0]         k;
  logic [RAM_WIDTH-1:0]  si, sj;
  logic                  fin_pend;
  logic                  start_rise;
  logic                  last_byte;

  edge_detector u_start_edge (
    .clk   (clk),
    .reset (reset),
    .sig   (start),
    .rise  (start_rise)
  );

  assign last_byte = (k == K_LAST);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (start_rise) next_state = ISSUE_I;
      ISSUE_I:   next_state = WAIT_SI;
      WAIT_SI:   next_state = READ_SI;
      READ_SI:   next_state = WAIT_SJ;
      WAIT_SJ:   next_state = READ_SJ;
      READ_SJ:   next_state = WRITE_J;
      WRITE_J:   next_state = ISSUE_F;
      ISSUE_F:   next_state = WAIT_F;
      WAIT_F:    next_state = WRITE_OUT;
      WRITE_OUT: next_state = last_byte ? IDLE : ISSUE_I;
      default:   next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      i                <= '0;
      j                <= '0;
      k                <= '0;
      si               <= '0;
      sj               <= '0;
      s_address        <= '0;
      s_ram_in         <= '0;
      s_write_enable   <= 1'b0;
      msg_address      <= '0;
      dec_ram_in       <= '0;
      dec_write_enable <= 1'b0;
      fin_pend         <= 1'b0;
      finished         <= 1'b0;
    end else begin
      dec_write_enable <= 1'b0;
      fin_pend         <= 1'b0;
      // finished trails the final result strobe by one cycle, so it is
      // raised once that write has actually landed in the result RAM.
      finished         <= fin_pend;
      case (state)
        IDLE: begin
          if (start_rise) begin
            i <= '0;
            j <= '0;
            k <= '0;
          end
        end
        ISSUE_I: begin
          i              <= i + 1'b1;
          s_address      <= i + 1'b1;
          s_write_enable <= 1'b0;
        end
        READ_SI: begin
          si        <= s_ram_out;
          j         <= j + RAM_LENGTH'(s_ram_out);
          s_address <= j + RAM_LENGTH'(s_ram_out);
        end
        READ_SJ: begin
          sj             <= s_ram_out;
          s_address      <= i;
          s_ram_in       <= s_ram_out;
          s_write_enable <= 1'b1;
        end
        WRITE_J: begin
          // When i==j both writes hit the same address with the same value.
          s_address      <= j;
          s_ram_in       <= si;
          s_write_enable <= 1'b1;
        end
        ISSUE_F: begin
          s_address      <= RAM_LENGTH'(si + sj);
          msg_address    <= k;
          s_write_enable <= 1'b0;
        end
        WRITE_OUT: begin
          // msg_address keeps the old k, so the result lands at index k.
          dec_ram_in       <= s_ram_out ^ msg_rom_out;
          dec_write_enable <= 1'b1;
          if (last_byte) fin_pend <= 1'b1;
          else           k        <= k + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_decryptor.sv
module tb_rc4_decryptor;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       finished;
  logic [7:0] s_ram_out;
  logic [7:0] s_address;
  logic [7:0] s_ram_in;
  logic       s_write_enable;
  logic [7:0] msg_rom_out;
  logic [1:0] msg_address;
  logic [7:0] dec_ram_in;
  logic       dec_write_enable;

  rc4_decryptor #(.RAM_WIDTH(8), .RAM_LENGTH(8), .MSG_LENGTH(3)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .finished         (finished),
    .s_ram_out        (s_ram_out),
    .s_address        (s_address),
    .s_ram_in         (s_ram_in),
    .s_write_enable   (s_write_enable),
    .msg_rom_out      (msg_rom_out),
    .msg_address      (msg_address),
    .dec_ram_in       (dec_ram_in),
    .dec_write_enable (dec_write_enable)
  );

  always #5 clk = ~clk;

  logic [7:0] s_mem   [256];
  logic [7:0] enc     [4];
  logic [7:0] dec_mem [4];
  logic       load_s = 1'b0;
  logic       clear_dec = 1'b0;

  always @(posedge clk) begin
    if (load_s) begin
      for (int x = 0; x < 256; x++) s_mem[x] <= 8'(x);
    end else if (s_write_enable) begin
      s_mem[s_address] <= s_ram_in;
    end
    s_ram_out <= s_mem[s_address];
  end

  always @(posedge clk) msg_rom_out <= enc[msg_address];

  always @(posedge clk) begin
    if (clear_dec) begin
      for (int x = 0; x < 4; x++) dec_mem[x] <= 8'hAA;
    end else if (dec_write_enable) begin
      dec_mem[msg_address] <= dec_ram_in;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int both_we = 0, wr_n = 0, dec_count = 0, dec_last = -1, fin_count = 0, fin_cyc = -1;
  logic [7:0] wr_addr [64];
  logic [7:0] wr_data [64];

  always @(negedge clk) begin
    if (s_write_enable && dec_write_enable) both_we++;
    if (s_write_enable && wr_n < 64) begin
      wr_addr[wr_n] = s_address;
      wr_data[wr_n] = s_ram_in;
      wr_n++;
    end
    if (dec_write_enable) begin
      dec_count++;
      dec_last = cyc;
    end
    if (finished) begin
      fin_count++;
      fin_cyc = cyc;
    end
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_s_address"},   32'(s_address), 0);
    check({tag, "_s_ram_in"},    32'(s_ram_in), 0);
    check({tag, "_s_we"},        32'(s_write_enable), 0);
    check({tag, "_msg_address"}, 32'(msg_address), 0);
    check({tag, "_dec_ram_in"},  32'(dec_ram_in), 0);
    check({tag, "_dec_we"},      32'(dec_write_enable), 0);
    check({tag, "_finished"},    32'(finished), 0);
  endtask

  task automatic load_state();
    @(negedge clk);
    load_s = 1'b1;
    clear_dec = 1'b1;
    @(negedge clk);
    load_s = 1'b0;
    clear_dec = 1'b0;
  endtask

  task automatic wait_fin(input int prev);
    for (int t = 0; t < 400 && fin_count == prev; t++) @(negedge clk);
    check("finished_timeout", 32'(fin_count > prev), 1);
  endtask

  int n0;

  initial begin
    for (int x = 0; x < 4; x++) enc[x] = 8'h00;
    reset = 1'b1;
    start = 1'b1;
    load_state();
    @(negedge clk);
    check_outputs_zero("reset");

    // start already high across reset release must not launch a run
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("no_run_after_reset_swr", 32'(wr_n), 0);
    check("no_run_after_reset_dec", 32'(dec_count), 0);

    // run 1: identity S, zero message, start then held high
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    n0 = cyc;
    wait_fin(0);
    check("fin_cycle",      32'(fin_cyc), 32'(n0 + 29));
    check("last_dec_cycle", 32'(dec_last), 32'(n0 + 28));
    @(negedge clk);
    check("fin_one_cycle",  32'(finished), 0);
    check("dec0", 32'(dec_mem[0]), 32'h02);
    check("dec1", 32'(dec_mem[1]), 32'h05);
    check("dec2", 32'(dec_mem[2]), 32'h07);
    check("s2",   32'(s_mem[2]), 32'h03);
    check("s3",   32'(s_mem[3]), 32'h05);
    check("s5",   32'(s_mem[5]), 32'h02);
    // byte 0 on identity S has i==j==1: both swap writes put 1 at address 1
    check("swap_wr0_addr", 32'(wr_addr[0]), 32'h01);
    check("swap_wr0_data", 32'(wr_data[0]), 32'h01);
    check("swap_wr1_addr", 32'(wr_addr[1]), 32'h01);
    check("swap_wr1_data", 32'(wr_data[1]), 32'h01);
    check("s1_unchanged",  32'(s_mem[1]), 32'h01);
    while (cyc < n0 + 500) @(negedge clk);
    check("held_start_runs", 32'(fin_count), 1);
    check("held_start_decs", 32'(dec_count), 3);

    // run 2: enc[0]=FF, with a second start pulse in the middle of the run
    start = 1'b0;
    enc[0] = 8'hFF;
    load_state();
    start = 1'b1;
    repeat (5) @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    wait_fin(1);
    repeat (60) @(negedge clk);
    check("glitch_runs", 32'(fin_count), 2);
    check("glitch_decs", 32'(dec_count), 6);
    check("ff_dec0", 32'(dec_mem[0]), 32'hFD);
    check("ff_dec1", 32'(dec_mem[1]), 32'h05);
    check("ff_dec2", 32'(dec_mem[2]), 32'h07);

    // run 3: reset during WRITE_J of byte 1, then a clean restart
    enc[0] = 8'h00;
    load_state();
    start = 1'b1;
    n0 = cyc;
    while (cyc < n0 + 15) @(negedge clk);
    check("writej_s_we",   32'(s_write_enable), 1);
    check("writej_s_addr", 32'(s_address), 32'h02);
    check("writej_s_data", 32'(s_ram_in), 32'h03);
    reset = 1'b1;
    @(negedge clk);
    check_outputs_zero("midrun_reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    load_state();
    start = 1'b1;
    wait_fin(2);
    repeat (10) @(negedge clk);
    check("restart_runs", 32'(fin_count), 3);
    check("restart_decs", 32'(dec_count), 10);
    check("restart_dec0", 32'(dec_mem[0]), 32'h02);
    check("restart_dec1", 32'(dec_mem[1]), 32'h05);
    check("restart_dec2", 32'(dec_mem[2]), 32'h07);
    check("we_overlap",   32'(both_we), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
